// File: rtl/cdp1802_pkg.sv
// Shared 1802 machine-cycle definitions: state codes driven on sc and the sequencer state set.
package cdp1802_pkg;

  localparam logic [1:0] SC_FETCH = 2'b00;
  localparam logic [1:0] SC_EXEC  = 2'b01;
  localparam logic [1:0] SC_DMA   = 2'b10;
  localparam logic [1:0] SC_INT   = 2'b11;

  typedef enum logic [2:0] {INIT, FETCH, EXEC, EXEC2, DMA, INT} cycle_state_e;

  // INIT and both execute cycles present themselves as S1 on the bus.
  function automatic logic [1:0] sc_of(cycle_state_e s);
    case (s)
      FETCH:   sc_of = SC_FETCH;
      DMA:     sc_of = SC_DMA;
      INT:     sc_of = SC_INT;
      default: sc_of = SC_EXEC;
    endcase
  endfunction

endpackage

// File: rtl/cdp1802_cycle_timer.sv
// T-state counter for one machine cycle, with TPA/TPB/cycle_end decoded from the count.
module cdp1802_cycle_timer #(
  parameter int CLOCKS_PER_CYCLE = 8,
  parameter int TPA_TICK         = 1,
  parameter int TPB_TICK         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  output logic [2:0] tcount,
  output logic       tpa,
  output logic       tpb,
  output logic       cycle_end
);

  localparam logic [2:0] LAST_T = 3'(CLOCKS_PER_CYCLE - 1);
  localparam logic [2:0] TPA_T  = 3'(TPA_TICK);
  localparam logic [2:0] TPB_T  = 3'(TPB_TICK);

  logic [2:0] tcount_q;
  logic [2:0] tcount_d;

  always_comb begin
    tcount_d = tcount_q;
    if (clk_enable) begin
      tcount_d = (tcount_q == LAST_T) ? 3'd0 : tcount_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcount_q <= 3'd0;
    end else begin
      tcount_q <= tcount_d;
    end
  end

  assign tcount    = tcount_q;
  assign tpa       = (tcount_q == TPA_T);
  assign tpb       = (tcount_q == TPB_T);
  assign cycle_end = (tcount_q == LAST_T);

endmodule

// File: rtl/cdp1802_cycle_scheduler.sv
// 1802 machine-cycle sequencer: picks fetch/execute/DMA/interrupt cycles and emits their strobes.
module cdp1802_cycle_scheduler
  import cdp1802_pkg::*;
#(
  parameter int CLOCKS_PER_CYCLE = 8,
  parameter int TPA_TICK         = 1,
  parameter int TPB_TICK         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic       exec_long,
  input  logic       idle_instr,
  input  logic       dma_in_req,
  input  logic       dma_out_req,
  input  logic       int_req,
  input  logic       ie,
  output logic [1:0] sc,
  output logic [2:0] tcount,
  output logic       tpa,
  output logic       tpb,
  output logic       cycle_end,
  output logic       dma_dir_out,
  output logic       r0_inc,
  output logic       int_ack,
  output logic       idle,
  output logic [2:0] state_dbg
);

  cycle_state_e state_q, state_d, arb_state;
  logic         dir_q, dir_d;
  logic         idle_q, idle_d;
  logic         want_dma, want_int;

  cdp1802_cycle_timer #(
    .CLOCKS_PER_CYCLE (CLOCKS_PER_CYCLE),
    .TPA_TICK         (TPA_TICK),
    .TPB_TICK         (TPB_TICK)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .tcount     (tcount),
    .tpa        (tpa),
    .tpb        (tpb),
    .cycle_end  (cycle_end)
  );

  // Priority at a cycle boundary: DMA-in, then DMA-out, then enabled interrupt, else fetch.
  assign want_dma  = dma_in_req | dma_out_req;
  assign want_int  = int_req & ie;
  assign arb_state = want_dma ? DMA : (want_int ? INT : FETCH);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idle_d  = idle_q;
    if (clk_enable && cycle_end) begin
      idle_d = 1'b0;
      case (state_q)
        FETCH: state_d = EXEC;
        INT:   state_d = FETCH;
        EXEC: begin
          if (exec_long) begin
            state_d = EXEC2;
          end else if (idle_instr && !want_dma && !want_int) begin
            state_d = EXEC;
            idle_d  = 1'b1;
          end else begin
            state_d = arb_state;
          end
        end
        default: state_d = arb_state;
      endcase
      if (state_d == DMA) begin
        dir_d = !dma_in_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      dir_q   <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idle_q  <= idle_d;
    end
  end

  assign sc          = sc_of(state_q);
  assign dma_dir_out = dir_q;
  assign idle        = idle_q;
  assign r0_inc      = tpb && (state_q == DMA);
  assign int_ack     = tpb && (state_q == INT);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_cdp1802_cycle_scheduler.sv
// Randomized bench for the 1802 cycle scheduler against a cycle-level behavioural model.
module tb_cdp1802_cycle_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_enable;
  logic       exec_long, idle_instr;
  logic       dma_in_req, dma_out_req, int_req, ie;
  logic [1:0] sc;
  logic [2:0] tcount;
  logic       tpa, tpb, cycle_end, dma_dir_out, r0_inc, int_ack, idle;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  cdp1802_cycle_scheduler u_dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .exec_long   (exec_long),
    .idle_instr  (idle_instr),
    .dma_in_req  (dma_in_req),
    .dma_out_req (dma_out_req),
    .int_req     (int_req),
    .ie          (ie),
    .sc          (sc),
    .tcount      (tcount),
    .tpa         (tpa),
    .tpb         (tpb),
    .cycle_end   (cycle_end),
    .dma_dir_out (dma_dir_out),
    .r0_inc      (r0_inc),
    .int_ack     (int_ack),
    .idle        (idle),
    .state_dbg   (state_dbg)
  );

  // Reference model: which kind of machine cycle is running and how many ticks into it.
  localparam int K_INIT = 0, K_FETCH = 1, K_EXEC1 = 2, K_EXEC2 = 3, K_DMA = 4, K_INT = 5;
  int   m_kind;
  int   m_tick;
  logic m_idle, m_dir;
  logic armed = 1'b0;

  function automatic logic [1:0] kind_sc(int k);
    if (k == K_FETCH) return 2'd0;
    if (k == K_DMA)   return 2'd2;
    if (k == K_INT)   return 2'd3;
    return 2'd1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  task automatic check_outputs();
    chk("sc",        8'(sc),          8'(kind_sc(m_kind)));
    chk("tcount",    8'(tcount),      8'(m_tick));
    chk("tpa",       8'(tpa),         8'(m_tick == 1));
    chk("tpb",       8'(tpb),         8'(m_tick == 6));
    chk("cycle_end", 8'(cycle_end),   8'(m_tick == 7));
    chk("dir",       8'(dma_dir_out), 8'(m_dir));
    chk("r0_inc",    8'(r0_inc),      8'(m_kind == K_DMA && m_tick == 6));
    chk("int_ack",   8'(int_ack),     8'(m_kind == K_INT && m_tick == 6));
    chk("idle",      8'(idle),        8'(m_idle));
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int  nk;
    logic any_dma, any_int;
    if (reset) begin
      m_kind = K_INIT; m_tick = 0; m_idle = 1'b0; m_dir = 1'b0; armed = 1'b1;
      return;
    end
    if (!clk_enable) return;
    if (m_tick < 7) begin
      m_tick++;
      return;
    end
    m_tick  = 0;
    any_dma = dma_in_req || dma_out_req;
    any_int = int_req && ie;
    if (any_dma)      nk = K_DMA;
    else if (any_int) nk = K_INT;
    else              nk = K_FETCH;
    m_idle = 1'b0;
    if (m_kind == K_FETCH) nk = K_EXEC1;
    else if (m_kind == K_INT) nk = K_FETCH;
    else if (m_kind == K_EXEC1) begin
      if (exec_long) nk = K_EXEC2;
      else if (idle_instr && !any_dma && !any_int) begin
        nk = K_EXEC1;
        m_idle = 1'b1;
      end
    end
    if (nk == K_DMA) m_dir = !dma_in_req;
    m_kind = nk;
  endtask

  // Sticky level requests: rare rise, quicker fall, so quiet windows and overlaps both occur.
  function automatic logic sticky(logic cur, int rise, int fall);
    if (!cur) return ($urandom_range(0, rise - 1) == 0);
    return !($urandom_range(0, fall - 1) == 0);
  endfunction

  task automatic drive_inputs(int cyc);
    reset       = (cyc < 3) || ($urandom_range(0, 399) == 0);
    clk_enable  = ($urandom_range(0, 9) != 0);
    exec_long   = ($urandom_range(0, 29) == 0) ? !exec_long  : exec_long;
    idle_instr  = ($urandom_range(0, 39) == 0) ? !idle_instr : idle_instr;
    ie          = ($urandom_range(0, 99) == 0) ? !ie         : ie;
    dma_in_req  = sticky(dma_in_req,  60, 10);
    dma_out_req = sticky(dma_out_req, 50, 12);
    int_req     = sticky(int_req,     40, 10);
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; exec_long = 1'b0; idle_instr = 1'b0;
    dma_in_req = 1'b0; dma_out_req = 1'b0; int_req = 1'b0; ie = 1'b1;
    m_kind = K_INIT; m_tick = 0; m_idle = 1'b0; m_dir = 1'b0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      if (armed) check_outputs();
      drive_inputs(cyc);
      @(posedge clk);
      model_step();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
